pio_tx_arb: RTL and testbench
=============================

PIO_TX_ARB -- requirements
Module: pio_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesting PIO TX FIFOs (range 2..8).
REQ-002 user_clk  in  1  SHALL be the clock for all logic.
REQ-003 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_req  in  N_REQ  SHALL carry per-requester "FIFO non-empty".
REQ-005 o_tkn  out  N_REQ  SHALL be a one-hot pop token; each asserted cycle pops exactly one beat from that requester.
REQ-006 i_tvalid/i_tlast  in  N_REQ each  SHALL carry per-requester beat qualifiers, zero unless that requester holds o_tkn.
REQ-007 i_tdata  in  N_REQ*512  and  i_tkeep  in  N_REQ*16  SHALL carry per-requester packed beats, zero unless tokened.
REQ-008 o_rq_axis_tvalid/tlast  out  1, o_rq_axis_tdata  out  512, o_rq_axis_tkeep  out  16  SHALL form the merged RQ AXI-Stream master.
REQ-009 i_rq_axis_tready  in  1  SHALL be the downstream ready.
REQ-010 o_busy  out  1  SHALL be high while a packet is locked.
REQ-011 o_err  out  1  SHALL be a sticky protocol-error flag.
REQ-012 o_pkt_cnt  out  32  SHALL count completed packets (tlast beats accepted downstream).

Function
REQ-013 The FSM SHALL have two states: IDLE and LOCK.
REQ-014 IDLE: winner = first requester with i_req high, searched round-robin starting at rr_ptr.
REQ-015 o_tkn[k] SHALL assert only when k is winner/owner, i_req[k]=1 and a beat can be accepted downstream in that cycle.
REQ-016 Merged outputs SHALL be the bitwise OR of all requester beats.
REQ-017 IDLE, token issued, i_tlast[k]=0 -> LOCK with owner=k.
REQ-018 IDLE, token issued, i_tlast[k]=1 -> remain IDLE; rr_ptr=(k+1) mod N_REQ.
REQ-019 LOCK: tokens SHALL go only to the owner; other requests are ignored until the owner's tlast beat pops.
REQ-020 LOCK, owner's tlast popped -> IDLE; rr_ptr=(owner+1) mod N_REQ.
REQ-021 LOCK with i_req[owner]=0 SHALL stall without token and without timeout.
REQ-022 o_err SHALL set when a token is issued and i_tvalid of that requester is 0, or when any i_tvalid is high for a non-tokened requester; it clears only on reset.
REQ-023 o_pkt_cnt SHALL increment by 1 per accepted tlast beat and wrap from 0xFFFFFFFF to 0.
REQ-024 i_rq_axis_tready low SHALL suppress all tokens; no beat is ever popped without being accepted or buffered.

Reset
REQ-025 On reset_n low: state=IDLE, rr_ptr=0, owner=0, o_tkn=0, all o_rq_axis_* =0, o_busy=0, o_err=0, o_pkt_cnt=0.
REQ-026 Reset asserted mid-packet SHALL abort the lock immediately; no partial-packet recovery.

Configuration
REQ-027 Macro PIO_TX_ARB_OUT_REG_EN defined: outputs SHALL pass through a 2-entry skid register (latency 1 cycle); a token SHALL issue only while the skid holds fewer than 2 entries after the current drain.
REQ-028 Macro undefined: outputs SHALL be combinational from the tokened beat (latency 0), and the token SHALL equal grant AND i_rq_axis_tready.

Structure
REQ-029 Shared package pio_trx_pkg SHALL hold the state enum, data/keep width constants (512, 16) and the N_REQ maximum.
REQ-030 Round-robin search SHALL live in sub-module pio_rr_pick (request vector + start pointer -> one-hot winner + valid).

Verification
REQ-031 Reset: hold reset_n=0 with i_req=4'b1111 -> o_tkn=0, o_rq_axis_tvalid=0, o_pkt_cnt=0.
REQ-032 Round-robin: i_req=4'b1111, all single-beat packets, tready=1 -> tokens rotate 0,1,2,3,0, one per cycle (no skid).
REQ-033 Lock: requester 2 sends a 3-beat packet while i_req=4'b1111 -> three consecutive tokens to 2, then token to 3; o_busy high for 2 cycles.
REQ-034 Backpressure: tready=0 for 5 cycles mid-packet -> o_tkn=0 for those cycles, no beat lost; with skid, at most 2 beats buffered.
REQ-035 Error: inject i_tvalid[1]=1 while the token is on 0 -> o_err=1 next cycle and stays 1 until reset.
REQ-036 Counter wrap: preload via 2^32 single-beat packets (or force) -> o_pkt_cnt goes 0xFFFFFFFF -> 0.

Source files
------------

// File: rtl/pio_trx_pkg.sv
// rtl/pio_trx_pkg.sv - shared widths, state encoding and pointer helper for the PIO TX arbiter
package pio_trx_pkg;

  localparam int PIO_DATA_W    = 512;
  localparam int PIO_KEEP_W    = 16;
  localparam int PIO_N_REQ_MAX = 8;
  localparam int PIO_PTR_W     = 3;
  localparam int PIO_BEAT_W    = PIO_DATA_W + PIO_KEEP_W + 1;

  typedef enum logic [0:0] {
    PIO_ST_IDLE = 1'b0,
    PIO_ST_LOCK = 1'b1
  } pio_state_e;

  // Advance a requester index by one, wrapping at the configured requester count.
  function automatic logic [PIO_PTR_W-1:0] pio_ptr_next(input logic [PIO_PTR_W-1:0] p,
                                                         input int n);
    return (p == PIO_PTR_W'(n - 1)) ? '0 : p + PIO_PTR_W'(1);
  endfunction

endpackage

// File: rtl/pio_tx_arb_if.sv
// rtl/pio_tx_arb_if.sv - merged RQ AXI-Stream bundle driven by the PIO TX arbiter
interface pio_tx_arb_if;
  import pio_trx_pkg::*;

  logic [PIO_DATA_W-1:0] tdata;
  logic [PIO_KEEP_W-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/pio_rr_pick.sv
// rtl/pio_rr_pick.sv - round-robin search: first set request at or after the start pointer
module pio_rr_pick
  import pio_trx_pkg::*;
#(
  parameter int N = 4
)
(
  input  logic [N-1:0]         req,
  input  logic [PIO_PTR_W-1:0] start,
  output logic [N-1:0]         win,
  output logic                 valid
);

  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_tx_arb.sv
// rtl/pio_tx_arb.sv - packet-locking round-robin merge of PIO TX FIFOs onto the RQ stream (PIO_TX_ARB_OUT_REG_EN adds a 2-entry output skid)
module pio_tx_arb
  import pio_trx_pkg::*;
#(
  parameter int N_REQ = 4
)
(
  input  logic                        user_clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            i_req,
  output logic [N_REQ-1:0]            o_tkn,
  input  logic [N_REQ-1:0]            i_tvalid,
  input  logic [N_REQ-1:0]            i_tlast,
  input  logic [N_REQ*PIO_DATA_W-1:0] i_tdata,
  input  logic [N_REQ*PIO_KEEP_W-1:0] i_tkeep,
  pio_tx_arb_if.master                rq_axis,
  output logic                        o_busy,
  output logic                        o_err,
  output logic [31:0]                 o_pkt_cnt
);

  localparam logic [0:0] ST_IDLE = PIO_ST_IDLE;
  localparam logic [0:0] ST_LOCK = PIO_ST_LOCK;

  logic [0:0]            state_q;
  logic [PIO_PTR_W-1:0]  rr_ptr_q;
  logic [PIO_PTR_W-1:0]  owner_q;
  logic                  err_q;
  logic [31:0]           pkt_cnt_q;

  logic [N_REQ-1:0]      pick_win;
  logic                  pick_vld;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      tkn;
  logic                  tkn_any;
  logic [PIO_PTR_W-1:0]  tkn_idx;
  logic                  can_issue;

  logic                  beat_valid;
  logic                  beat_last;
  logic [PIO_DATA_W-1:0] beat_data;
  logic [PIO_KEEP_W-1:0] beat_keep;
  logic                  stray_valid;
  logic                  err_set;
  logic                  out_accept_last;

  pio_rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req   (i_req),
    .start (rr_ptr_q),
    .win   (pick_win),
    .valid (pick_vld)
  );

  // While locked only the owner may pop; an owner with an empty FIFO simply stalls.
  always_comb begin
    grant = '0;
    if (state_q == ST_LOCK) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (owner_q == PIO_PTR_W'(k)) begin
          grant[k] = i_req[k];
        end
      end
    end else if (pick_vld) begin
      grant = pick_win;
    end
  end

  assign tkn     = reset_n ? (grant & {N_REQ{can_issue}}) : '0;
  assign tkn_any = |tkn;
  assign o_tkn   = tkn;

  // Only the tokened requester's beat is merged, so a misbehaving idle FIFO cannot corrupt the stream.
  always_comb begin
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_data  = '0;
    beat_keep  = '0;
    tkn_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (tkn[k]) begin
        tkn_idx    = PIO_PTR_W'(k);
        beat_valid = beat_valid | i_tvalid[k];
        beat_last  = beat_last  | i_tlast[k];
        beat_data  = beat_data  | i_tdata[k*PIO_DATA_W +: PIO_DATA_W];
        beat_keep  = beat_keep  | i_tkeep[k*PIO_KEEP_W +: PIO_KEEP_W];
      end
    end
  end

  assign stray_valid     = |(i_tvalid & ~tkn);
  assign err_set         = (tkn_any & ~beat_valid) | stray_valid;
  assign out_accept_last = rq_axis.tvalid & rq_axis.tlast & rq_axis.tready;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (out_accept_last) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (tkn_any) begin
        if (beat_last) begin
          state_q  <= ST_IDLE;
          rr_ptr_q <= pio_ptr_next(tkn_idx, N_REQ);
        end else if (state_q == ST_IDLE) begin
          state_q <= ST_LOCK;
          owner_q <= tkn_idx;
        end
      end
    end
  end

  assign o_busy    = (state_q == ST_LOCK);
  assign o_err     = err_q;
  assign o_pkt_cnt = pkt_cnt_q;

`ifdef PIO_TX_ARB_OUT_REG_EN
  logic [1:0]            sk_cnt_q;
  logic [PIO_BEAT_W-1:0] sk_e0_q;
  logic [PIO_BEAT_W-1:0] sk_e1_q;
  logic [PIO_BEAT_W-1:0] sk_in;
  logic                  sk_drain;

  assign sk_in     = {beat_last, beat_keep, beat_data};
  assign sk_drain  = (sk_cnt_q != 2'd0) & rq_axis.tready;
  // Counting the same-cycle drain lets a full skid keep streaming at one beat per cycle.
  assign can_issue = (sk_cnt_q - {1'b0, sk_drain}) < 2'd2;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      sk_cnt_q <= 2'd0;
      sk_e0_q  <= '0;
      sk_e1_q  <= '0;
    end else begin
      case ({tkn_any, sk_drain})
        2'b10: begin
          if (sk_cnt_q == 2'd0) begin
            sk_e0_q <= sk_in;
          end else begin
            sk_e1_q <= sk_in;
          end
          sk_cnt_q <= sk_cnt_q + 2'd1;
        end
        2'b01: begin
          sk_e0_q  <= sk_e1_q;
          sk_cnt_q <= sk_cnt_q - 2'd1;
        end
        2'b11: begin
          if (sk_cnt_q == 2'd1) begin
            sk_e0_q <= sk_in;
          end else begin
            sk_e0_q <= sk_e1_q;
            sk_e1_q <= sk_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rq_axis.tvalid = (sk_cnt_q != 2'd0);
  assign rq_axis.tlast  = sk_e0_q[PIO_BEAT_W-1];
  assign rq_axis.tkeep  = sk_e0_q[PIO_DATA_W +: PIO_KEEP_W];
  assign rq_axis.tdata  = sk_e0_q[PIO_DATA_W-1:0];
`else
  assign can_issue      = rq_axis.tready;
  assign rq_axis.tvalid = beat_valid;
  assign rq_axis.tlast  = beat_last;
  assign rq_axis.tkeep  = beat_keep;
  assign rq_axis.tdata  = beat_data;
`endif

endmodule

// File: tb/tb_pio_tx_arb.sv
// tb/tb_pio_tx_arb.sv - self-checking bench for pio_tx_arb (default build, combinational outputs)
module tb_pio_tx_arb;
  import pio_trx_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] exp_tkn;
  } vec_t;

  logic                     user_clk = 1'b0;
  logic                     reset_n  = 1'b0;
  logic [N-1:0]             i_req;
  logic [N-1:0]             o_tkn;
  logic [N-1:0]             i_tvalid;
  logic [N-1:0]             i_tlast;
  logic [N*PIO_DATA_W-1:0]  i_tdata;
  logic [N*PIO_KEEP_W-1:0]  i_tkeep;
  logic                     o_busy;
  logic                     o_err;
  logic [31:0]              o_pkt_cnt;

  pio_tx_arb_if rq_if ();

  pio_tx_arb #(.N_REQ(N)) dut (
    .user_clk  (user_clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .o_tkn     (o_tkn),
    .i_tvalid  (i_tvalid),
    .i_tlast   (i_tlast),
    .i_tdata   (i_tdata),
    .i_tkeep   (i_tkeep),
    .rq_axis   (rq_if),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .o_pkt_cnt (o_pkt_cnt)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beats left per requester, lock owner, next search start, packet total, error flag.
  int          rem [N];
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  logic [31:0] m_cnt;
  bit          m_err;

  logic [PIO_DATA_W-1:0] drv_data;
  logic [PIO_KEEP_W-1:0] drv_keep;
  logic                  drv_last;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_token(input logic [3:0] req, input logic rdy);
    logic [3:0] t;
    int k;
    t = '0;
    if (!rdy) return t;
    if (m_locked) begin
      if (req[m_owner]) t[m_owner] = 1'b1;
      return t;
    end
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (req[k]) begin
        t[k] = 1'b1;
        return t;
      end
    end
    return t;
  endfunction

  task automatic clear_beats();
    i_tvalid = '0;
    i_tlast  = '0;
    i_tdata  = '0;
    i_tkeep  = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) rem[k] = 0;
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cnt    = '0;
    m_err    = 0;
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    reset_n      = 1'b0;
    i_req        = 4'b1111;
    rq_if.tready = 1'b1;
    clear_beats();
    #1;
    chk("rst_tkn", o_tkn, 4'b0000);
    chk("rst_tvalid", rq_if.tvalid, 1'b0);
    chk("rst_pkt_cnt", o_pkt_cnt, 32'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err", o_err, 1'b0);
    repeat (2) @(negedge user_clk);
    i_req   = '0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input logic [3:0] req, input logic rdy, input logic [3:0] bad_valid,
                       output logic [3:0] tkn_seen, output logic busy_seen);
    logic [3:0] exp_t;
    int k;
    bit last;
    @(negedge user_clk);
    chk("pkt_cnt", o_pkt_cnt, m_cnt);
    chk("err", o_err, m_err);
    i_req        = req;
    rq_if.tready = rdy;
    clear_beats();
    #1;
    exp_t = model_token(req, rdy);
    chk("tkn", o_tkn, exp_t);
    chk("busy", o_busy, m_locked);
    tkn_seen  = o_tkn;
    busy_seen = o_busy;
    k = -1;
    for (int i = 0; i < N; i++) if (o_tkn[i]) k = i;
    if (k >= 0) begin
      for (int w = 0; w < 16; w++) drv_data[w*32 +: 32] = $urandom;
      drv_keep = 16'($urandom);
      drv_last = (rem[k] <= 1);
      i_tvalid[k] = 1'b1;
      i_tlast[k]  = drv_last;
      i_tdata[k*PIO_DATA_W +: PIO_DATA_W] = drv_data;
      i_tkeep[k*PIO_KEEP_W +: PIO_KEEP_W] = drv_keep;
    end
    i_tvalid = i_tvalid | bad_valid;
    #1;
    chk("out_tvalid", rq_if.tvalid, |exp_t);
    if (|exp_t) begin
      chk("out_tlast", rq_if.tlast, drv_last);
      chk("out_tdata", rq_if.tdata, drv_data);
      chk("out_tkeep", rq_if.tkeep, drv_keep);
      for (int i = 0; i < N; i++) if (exp_t[i]) k = i;
      last = (rem[k] <= 1);
      if (rem[k] > 0) rem[k]--;
      if (last) begin
        m_locked = 0;
        m_ptr    = (k + 1) % N;
        m_cnt    = m_cnt + 32'd1;
      end else begin
        m_locked = 1;
        m_owner  = k;
      end
    end
    if (|(bad_valid & ~exp_t)) m_err = 1;
  endtask

  initial begin
    vec_t       tbl [12];
    logic [3:0] lk_t [4];
    logic       lk_b [4];
    logic [3:0] bp_t [10];
    logic       bp_r [10];
    logic [3:0] t;
    logic       b;
    logic [3:0] rreq;
    logic       rrdy;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[6]  = '{4'b1001, 1'b1, 4'b1000};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[8]  = '{4'b0110, 1'b1, 4'b0010};
    tbl[9]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[10] = '{4'b1101, 1'b1, 4'b0100};
    tbl[11] = '{4'b0011, 1'b1, 4'b0001};
    lk_t = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
    lk_b = '{1'b0, 1'b1, 1'b1, 1'b0};
    bp_r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_t = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
             4'b0001, 4'b0001, 4'b0010};

    i_req        = '0;
    rq_if.tready = 1'b0;
    clear_beats();
    model_reset();

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].req, tbl[i].rdy, 4'b0000, t, b);
      chk($sformatf("tbl%0d_tkn", i), t, tbl[i].exp_tkn);
    end

    // Requester 2 sends a 3-beat packet while everyone requests.
    do_reset();
    cycle(4'b1111, 1'b1, 4'b0000, t, b);
    cycle(4'b1111, 1'b1, 4'b0000, t, b);
    rem[2] = 3;
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 1'b1, 4'b0000, t, b);
      chk($sformatf("lock%0d_tkn", i), t, lk_t[i]);
      chk($sformatf("lock%0d_busy", i), b, lk_b[i]);
    end

    // Five cycles of backpressure in the middle of a 4-beat packet from requester 0.
    rem[0] = 4;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1111, bp_r[i], 4'b0000, t, b);
      chk($sformatf("bp%0d_tkn", i), t, bp_t[i]);
    end

    // Stray tvalid from requester 1 while requester 0 holds the token.
    do_reset();
    cycle(4'b0001, 1'b1, 4'b0010, t, b);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 4'b0000, t, b);
    chk("err_sticky", o_err, 1'b1);
    do_reset();

    // Packet counter wrap.
    @(negedge user_clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    cycle(4'b0001, 1'b1, 4'b0000, t, b);
    @(posedge user_clk);
    #1;
    chk("wrap_ffffffff", o_pkt_cnt, 32'hFFFF_FFFF);
    cycle(4'b0010, 1'b1, 4'b0000, t, b);
    @(posedge user_clk);
    #1;
    chk("wrap_zero", o_pkt_cnt, 32'd0);

    // Random traffic with variable packet lengths, request dropouts and backpressure.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 2) == 0) rem[k] = $urandom_range(1, 4);
        rreq[k] = (rem[k] > 0);
        if (rreq[k] && $urandom_range(0, 7) == 0) rreq[k] = 1'b0;
      end
      rrdy = ($urandom_range(0, 4) != 0);
      cycle(rreq, rrdy, 4'b0000, t, b);
    end
    cycle(4'b0000, 1'b0, 4'b0000, t, b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
